rt_microsequencer: RTL

//  Micro-op sequencer for the 4-bit register-transfer datapath (R1..R3, DR1/DR2, ALU, AC, OUTR, shared bus).
//  - Accepts one instruction at a time over a valid/ready handshake.
//  - Expands it into timed steps T0..T3 that drive the bus source select and the one-cycle register load enables.
//  - Replaces the free-running counter/decoder timing with instruction-driven sequencing, stall and completion status.

---
 rtl/rt_microsequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rt_microsequencer.sv
// Micro-op sequencer for the 4-bit register-transfer datapath: accepts one instruction over a
// valid/ready handshake and steps it through T0..T3, driving bus source select and load enables.
module rt_microsequencer #(
  parameter int unsigned RID_W = 2,
  parameter int unsigned SRC_W = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       instr_op,
  input  logic [RID_W-1:0] instr_a,
  input  logic [RID_W-1:0] instr_b,
  input  logic [RID_W-1:0] instr_dst,
  input  logic             stall,
  output logic [SRC_W-1:0] bus_src,
  output logic [2:0]       ld_r,
  output logic             ld_dr1,
  output logic             ld_dr2,
  output logic             ld_ac,
  output logic             ld_outr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {StIdle, StT0, StT1, StT2, StT3} state_e;

  localparam logic [1:0] OpNop = 2'b00;
  localparam logic [1:0] OpMov = 2'b01;
  localparam logic [1:0] OpAdd = 2'b10;
  localparam logic [1:0] OpOut = 2'b11;

  localparam logic [RID_W-1:0] RidAc = RID_W'(3);
  localparam logic [SRC_W-1:0] SrcNone = '0;
  localparam logic [SRC_W-1:0] SrcAc = SRC_W'(4);

  state_e           state_q;
  logic [1:0]       op_q;
  logic [RID_W-1:0] a_q, b_q, dst_q;
  logic [CNT_W-1:0] retired_q;

  logic             dst_illegal;
  logic [2:0]       ld_r_raw;
  logic             ld_dr1_raw, ld_dr2_raw, ld_ac_raw, ld_outr_raw, done_raw, err_raw;

  // Register index maps onto the bus source code by a +1 offset (0 means nothing drives the bus).
  function automatic logic [SRC_W-1:0] src_of(input logic [RID_W-1:0] idx);
    return SRC_W'(idx) + SRC_W'(1);
  endfunction

  function automatic logic [2:0] ld_of(input logic [RID_W-1:0] idx);
    return 3'b001 << idx;
  endfunction

  assign dst_illegal = ((op_q == OpMov) || (op_q == OpAdd)) && (dst_q == RidAc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpNop;
      a_q       <= '0;
      b_q       <= '0;
      dst_q     <= '0;
      retired_q <= '0;
    end else begin
      if (done) retired_q <= retired_q + CNT_W'(1);
      case (state_q)
        StIdle: begin
          if (instr_valid && instr_ready) begin
            op_q    <= instr_op;
            a_q     <= instr_a;
            b_q     <= instr_b;
            dst_q   <= instr_dst;
            state_q <= StT0;
          end
        end
        StT0: begin
          if (!stall) state_q <= (op_q == OpAdd && !dst_illegal) ? StT1 : StIdle;
        end
        StT1: if (!stall) state_q <= StT2;
        StT2: if (!stall) state_q <= StT3;
        StT3: if (!stall) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Step decode from state and latched instruction only.
  always_comb begin
    bus_src     = SrcNone;
    ld_r_raw    = 3'b000;
    ld_dr1_raw  = 1'b0;
    ld_dr2_raw  = 1'b0;
    ld_ac_raw   = 1'b0;
    ld_outr_raw = 1'b0;
    done_raw    = 1'b0;
    err_raw     = 1'b0;
    case (state_q)
      StT0: begin
        if (dst_illegal) begin
          done_raw = 1'b1;
          err_raw  = 1'b1;
        end else begin
          unique case (op_q)
            OpNop: done_raw = 1'b1;
            OpMov: begin
              bus_src  = src_of(a_q);
              ld_r_raw = ld_of(dst_q);
              done_raw = 1'b1;
            end
            OpOut: begin
              bus_src     = src_of(a_q);
              ld_outr_raw = 1'b1;
              done_raw    = 1'b1;
            end
            OpAdd: begin
              bus_src    = src_of(a_q);
              ld_dr1_raw = 1'b1;
            end
          endcase
        end
      end
      StT1: begin
        bus_src    = src_of(b_q);
        ld_dr2_raw = 1'b1;
      end
      StT2: ld_ac_raw = 1'b1;
      StT3: begin
        bus_src  = SrcAc;
        ld_r_raw = ld_of(dst_q);
        done_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // A stall freezes the step: bus_src stays put, but no load or completion may fire.
  always_comb begin
    ld_r    = stall ? 3'b000 : ld_r_raw;
    ld_dr1  = ld_dr1_raw  & ~stall;
    ld_dr2  = ld_dr2_raw  & ~stall;
    ld_ac   = ld_ac_raw   & ~stall;
    ld_outr = ld_outr_raw & ~stall;
    done    = done_raw    & ~stall;
    err     = err_raw     & ~stall;
  end

  assign instr_ready = (state_q == StIdle) & ~stall;
  assign busy        = (state_q != StIdle);
  assign retired     = retired_q;

endmodule
